// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - oversampled UART transmitter with a one-entry holding buffer and optional parity
module uart_tx_param #(
  parameter int DBIT    = 8,
  parameter int OS      = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  input  logic [1:0]      par_mode,
  input  logic            s_tick,
  output logic            tx_ready,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int CMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int CW   = $clog2(CMAX);
  localparam int NW   = $clog2(DBIT);
  localparam logic [CW-1:0] OS_LAST = CW'(OS - 1);
  localparam logic [CW-1:0] SB_LAST = CW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            par_en_reg, par_en_next;
  logic            par_bit_reg, par_bit_next;
  logic            tx_reg, tx_next;
  logic            done_reg, done_next;
  logic [DBIT-1:0] buf_data;
  logic [1:0]      buf_mode;
  logic            buf_full;
  logic            load;
  logic            accept;

  // Load can only happen with the buffer full, so it never coincides with an accepted write.
  assign accept = tx_start & ~buf_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_data <= '0;
      buf_mode <= '0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_data <= din;
      buf_mode <= par_mode;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      s_reg       <= '0;
      n_reg       <= '0;
      b_reg       <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      tx_reg      <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      s_reg       <= s_next;
      n_reg       <= n_next;
      b_reg       <= b_next;
      par_en_reg  <= par_en_next;
      par_bit_reg <= par_bit_next;
      tx_reg      <= tx_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    s_next       = s_reg;
    n_next       = n_reg;
    b_next       = b_reg;
    par_en_next  = par_en_reg;
    par_bit_next = par_bit_reg;
    tx_next      = tx_reg;
    done_next    = 1'b0;
    load         = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (buf_full) load = 1'b1;
      end
      START: begin
        if (s_tick) begin
          if (s_reg == OS_LAST) begin
            state_next = DATA;
            s_next     = '0;
            n_next     = '0;
            tx_next    = b_reg[0];
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == OS_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) begin
              if (par_en_reg) begin
                state_next = PARITY;
                tx_next    = par_bit_reg;
              end else begin
                state_next = STOP;
                tx_next    = 1'b1;
              end
            end else begin
              n_next  = n_reg + 1'b1;
              tx_next = b_reg[1];
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_reg == OS_LAST) begin
            state_next = STOP;
            s_next     = '0;
            tx_next    = 1'b1;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == SB_LAST) begin
            done_next = 1'b1;
            s_next    = '0;
            if (buf_full) begin
              load = 1'b1;
            end else begin
              state_next = IDLE;
              tx_next    = 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Parity is precomputed from the buffered word so the shifting data register never feeds it.
    if (load) begin
      state_next   = START;
      s_next       = '0;
      n_next       = '0;
      b_next       = buf_data;
      par_en_next  = buf_mode[0] ^ buf_mode[1];
      par_bit_next = (^buf_data) ^ (buf_mode == 2'b10);
      tx_next      = 1'b0;
    end
  end

  assign tx           = tx_reg;
  assign tx_busy      = (state_reg != IDLE);
  assign tx_done_tick = done_reg;
  assign tx_ready     = ~buf_full;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - randomized bench for uart_tx_param against a slot-based line model
module tb_uart_tx_param;

  localparam int DBIT = 8;
  localparam int OS   = 16;
  localparam int SB   = 16;
  localparam int SB2  = 32;

  typedef struct packed {
    logic [DBIT-1:0] data;
    logic [1:0]      mode;
  } frame_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            tx_start = 1'b0;
  logic            s_tick = 1'b0;
  logic [DBIT-1:0] din = '0;
  logic [1:0]      par_mode = '0;
  logic            tx, tx_ready, tx_busy, tx_done_tick;
  logic            tx2, tx_ready2, tx_busy2, tx_done_tick2;

  int total = 0;
  int bad   = 0;

  frame_t exp_q[$];
  frame_t cur;
  bit     cur_valid = 0;
  bit     done_due = 0;
  int     rx_pos = -1;
  int     rx_len = 0;
  int     rx_err = 0;
  int     gap_cnt = 0;
  int     last_gap = -1;
  int     n_frames = 0;
  int     n_unexp = 0;
  int     n_done = 0;
  int     n_done2 = 0;
  int     run_len0 = 0;
  int     run_len1 = 0;
  int     runs0[$];
  int     runs1[$];

  uart_tx_param #(.DBIT(DBIT), .OS(OS), .SB_TICK(SB)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .din(din), .par_mode(par_mode),
    .s_tick(s_tick), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .tx_done_tick(tx_done_tick), .tx(tx)
  );

  uart_tx_param #(.DBIT(DBIT), .OS(OS), .SB_TICK(SB2)) dut2 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .din(din), .par_mode(par_mode),
    .s_tick(s_tick), .tx_ready(tx_ready2), .tx_busy(tx_busy2),
    .tx_done_tick(tx_done_tick2), .tx(tx2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, want);
    end
  endtask

  function automatic int par_on(input logic [1:0] m);
    return (m == 2'b01 || m == 2'b10) ? 1 : 0;
  endfunction

  // Line level expected at s_tick sample p of a frame: slot 0 start, then data LSB first, parity, stop.
  function automatic logic exp_bit(input frame_t f, input int p);
    int slot;
    slot = p / OS;
    if (slot == 0) return 1'b0;
    if (slot <= DBIT) return f.data[slot-1];
    if (par_on(f.mode) == 1 && slot == DBIT + 1) return (^f.data) ^ (f.mode == 2'b10);
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      s_tick = ($urandom_range(0, 1) == 1);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      rx_pos   = -1;
      done_due = 0;
      gap_cnt  = 0;
      run_len0 = 0;
      run_len1 = 0;
      runs0.delete();
      runs1.delete();
    end else begin
      if (done_due) begin
        check("done_at_stop_end", tx_done_tick, 1);
        done_due = 0;
      end
      if (tx_done_tick) n_done++;
      if (tx_done_tick2) n_done2++;
      if (s_tick) begin
        if (tx === 1'b1) run_len0++;
        else begin
          if (run_len0 > 0) runs0.push_back(run_len0);
          run_len0 = 0;
        end
        if (tx2 === 1'b1) run_len1++;
        else begin
          if (run_len1 > 0) runs1.push_back(run_len1);
          run_len1 = 0;
        end
        if (rx_pos < 0) begin
          if (tx === 1'b0) begin
            last_gap = gap_cnt;
            gap_cnt  = 0;
            rx_pos   = 1;
            rx_err   = 0;
            n_frames++;
            cur_valid = (exp_q.size() > 0);
            if (cur_valid) cur = exp_q.pop_front();
            else begin
              n_unexp++;
              cur = '0;
            end
            rx_len = OS * (1 + DBIT + par_on(cur.mode)) + SB;
          end else begin
            gap_cnt++;
          end
        end else begin
          if (tx !== exp_bit(cur, rx_pos)) rx_err++;
          rx_pos++;
          if (rx_pos == rx_len) begin
            rx_pos = -1;
            if (cur_valid) begin
              check("frame_bits", rx_err, 0);
              done_due = 1;
            end
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DBIT-1:0] d, input logic [1:0] m);
    din = d;
    par_mode = m;
    tx_start = 1'b1;
    cyc();
    exp_q.push_back('{data: d, mode: m});
    tx_start = 1'b0;
    din = DBIT'($urandom);
    par_mode = 2'($urandom);
    check("ready_low_after_write", tx_ready, 0);
  endtask

  task automatic spur();
    din = DBIT'($urandom);
    par_mode = 2'($urandom);
    tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (tx_ready !== 1'b1 && k < budget) begin
      cyc();
      k++;
    end
    check("ready_timeout", tx_ready, 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      cyc();
      k++;
    end
    check("done_timeout", (n_done >= target), 1);
  endtask

  task automatic run_frame(input logic [DBIT-1:0] d, input logic [1:0] m);
    int b, f;
    b = n_done;
    f = n_frames;
    put(d, m);
    wait_done(b + 1, 3000);
    repeat (30) cyc();
    check("frame_count", n_frames, f + 1);
    check("done_once", n_done, b + 1);
    check("idle_after_frame", tx_busy, 0);
    check("line_idle_high", tx, 1);
  endtask

  initial begin
    int b, f, b2, k;
    logic [DBIT-1:0] d;
    logic [1:0] m;

    reset = 1'b1;
    repeat (3) cyc();
    check("reset_tx", tx, 1);
    check("reset_ready", tx_ready, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done_tick, 0);
    reset = 1'b0;
    repeat (5) cyc();

    run_frame(8'hA5, 2'b00);
    run_frame(8'hA5, 2'b01);
    run_frame(8'hA5, 2'b10);
    run_frame(8'h3C, 2'b11);

    b = n_done;
    f = n_frames;
    put(8'h55, 2'b00);
    wait_ready(100);
    put(8'h0F, 2'b00);
    spur();
    wait_done(b + 2, 6000);
    repeat (400) cyc();
    check("b2b_gap", last_gap, 0);
    check("b2b_frames", n_frames, f + 2);
    check("b2b_done", n_done, b + 2);
    check("b2b_no_extra", n_unexp, 0);

    for (int i = 0; i < 20; i++) begin
      d = DBIT'($urandom);
      m = 2'($urandom_range(0, 3));
      wait_ready(3000);
      repeat ($urandom_range(0, 3)) cyc();
      b = n_done;
      put(d, m);
      if ($urandom_range(0, 1) == 1) spur();
    end
    wait_done(b + 1, 6000);
    wait_done(n_done + exp_q.size(), 6000);
    repeat (400) cyc();
    check("rand_no_extra", n_unexp, 0);
    check("rand_queue_empty", exp_q.size(), 0);

    reset = 1'b1;
    exp_q.delete();
    repeat (2) cyc();
    reset = 1'b0;
    repeat (3) cyc();
    b2 = n_done2;
    put(8'h0F, 2'b00);
    k = 0;
    while (!(tx_ready === 1'b1 && tx_ready2 === 1'b1) && k < 100) begin
      cyc();
      k++;
    end
    check("stop2_ready", tx_ready2, 1);
    put(8'h0F, 2'b00);
    k = 0;
    while (n_done2 < b2 + 2 && k < 8000) begin
      cyc();
      k++;
    end
    check("stop2_done", n_done2, b2 + 2);
    check("stop_runs_cnt", (runs0.size() >= 3 && runs1.size() >= 3), 1);
    if (runs0.size() >= 3 && runs1.size() >= 3) begin
      check("stop1_len", runs0[runs0.size()-2], SB);
      check("stop2_len", runs1[runs1.size()-2], SB2);
      check("stop2_data_run", runs1[runs1.size()-1], 4 * OS);
    end
    repeat (200) cyc();

    b = n_done;
    f = n_frames;
    put(8'hA5, 2'b00);
    wait_ready(100);
    put(8'h3C, 2'b01);
    k = 0;
    while (rx_pos < OS * 4 + OS / 2 && k < 4000) begin
      cyc();
      k++;
    end
    check("reach_bit3", (rx_pos >= OS * 4 + OS / 2), 1);
    reset = 1'b1;
    exp_q.delete();
    cyc();
    check("abort_tx", tx, 1);
    check("abort_ready", tx_ready, 1);
    check("abort_busy", tx_busy, 0);
    check("abort_done", tx_done_tick, 0);
    reset = 1'b0;
    repeat (1500) cyc();
    check("abort_no_done", n_done, b);
    check("abort_frames", n_frames, f + 1);
    check("abort_buffer_dropped", tx_busy, 0);
    check("abort_no_extra", n_unexp, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
